// File: rtl/mem_pkg.sv
// Shared definitions for the mem_req CPU-to-memory request bridge:
// bus widths, read/write flag encoding and FSM state encodings.
package mem_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  // 6502 convention: rw high means read
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Bridge FSM state enumeration (fixed legacy encodings)
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_REQ     = 2'd1;
  localparam state_t ST_RD_WAIT = 2'd2;
  localparam state_t ST_ERROR   = 2'd3;

endpackage

// File: rtl/mem_req_if.sv
// CPU-side bus cycle and memory-controller request signals of mem_req.
// slave  : the bridge's view (accepts CPU cycles, issues memory requests)
// master : the surrounding system's view (CPU plus memory controller)
interface mem_req_if;
  import mem_pkg::*;

  logic              cpu_valid;
  logic              cpu_rw;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_rdy;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rdata_valid;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read_en;
  logic              mem_write_en;
  logic              mem_busy;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdata_valid;

  logic              bus_err;

  modport slave (
    input  cpu_valid, cpu_rw, cpu_addr, cpu_wdata,
    input  mem_busy, mem_rdata, mem_rdata_valid,
    output cpu_rdy, cpu_rdata, cpu_rdata_valid,
    output mem_addr, mem_wdata, mem_read_en, mem_write_en,
    output bus_err
  );

  modport master (
    output cpu_valid, cpu_rw, cpu_addr, cpu_wdata,
    output mem_busy, mem_rdata, mem_rdata_valid,
    input  cpu_rdy, cpu_rdata, cpu_rdata_valid,
    input  mem_addr, mem_wdata, mem_read_en, mem_write_en,
    input  bus_err
  );

endinterface

// File: rtl/mem_req_timer.sv
// Outstanding-access watchdog for mem_req: counts cycles spent waiting on the
// memory controller and flags expiry once the count reaches TIMEOUT.
module mem_req_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic run,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] cnt_q, cnt_d;

  // Restart on a new access, otherwise count while waiting; saturate so it never wraps
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (run && (cnt_q != '1)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = run && (cnt_q >= LIMIT);

endmodule

// File: rtl/mem_req.sv
// mem_req: bridges single CPU bus cycles onto a memory controller that may be
// busy (BIST or a prior access). One access outstanding at a time.
// Optional feature: define MEM_REQ_TIMEOUT_EN to build the access watchdog
// (mem_req_timer) and the sticky bus_err / ERROR state; without it waits are
// unbounded and bus_err is tied low.
module mem_req
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  mem_req_if.slave   bus
);

  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("mem_req: TIMEOUT must be in 1..255");
  end

  state_t            state_q, state_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              rdy_q, rdy_d;

  logic              xfer;
  logic              accept;
  logic              expired;

  // rdy_q is high exactly in IDLE, so it doubles as the transfer qualifier
  assign xfer   = bus.cpu_valid && rdy_q;
  assign accept = (state_q == ST_REQ) && !bus.mem_busy;

  // Next-state and datapath capture
  always_comb begin
    state_d  = state_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          rw_d    = bus.cpu_rw;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // an accepted request takes priority over a watchdog expiry
        if (accept) begin
          state_d = (rw_q == RW_READ) ? ST_RD_WAIT : ST_IDLE;
        end else if (expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_RD_WAIT: begin
        // completion in the expiry cycle still completes normally
        if (bus.mem_rdata_valid) begin
          rdata_d  = bus.mem_rdata;
          rvalid_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    rdy_d = (state_d == ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      rw_q     <= RW_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rdy_q    <= rdy_d;
    end
  end

`ifdef MEM_REQ_TIMEOUT_EN
  logic run;
  logic err_q, err_d;

  assign run = (state_q == ST_REQ) || (state_q == ST_RD_WAIT);

  mem_req_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (xfer),
    .run     (run),
    .expired (expired)
  );

  // Sticky error flag mirrors entry into ERROR
  always_comb begin
    err_d = (state_d == ST_ERROR);
  end

  // Error flag register
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.bus_err = err_q;
`else
  assign expired     = 1'b0;
  assign bus.bus_err = 1'b0;
`endif

  assign bus.cpu_rdy         = rdy_q;
  assign bus.cpu_rdata       = rdata_q;
  assign bus.cpu_rdata_valid = rvalid_q;
  assign bus.mem_addr        = addr_q;
  assign bus.mem_wdata       = wdata_q;
  assign bus.mem_read_en     = accept && (rw_q == RW_READ);
  assign bus.mem_write_en    = accept && (rw_q == RW_WRITE);

endmodule

// File: tb/tb_mem_req.sv
// Directed self-checking bench for mem_req. dut uses TIMEOUT=255 for the
// functional scenarios; dut_t uses TIMEOUT=16 for the watchdog scenario.
module tb_mem_req;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total   = 0;
  int   bad     = 0;
  int   overlap = 0;

  mem_req_if bus ();
  mem_req_if bus_t ();

  mem_req #(.TIMEOUT(255)) dut   (.clk(clk), .reset(reset), .bus(bus.slave));
  mem_req #(.TIMEOUT(16))  dut_t (.clk(clk), .reset(reset), .bus(bus_t.slave));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_read_en && bus.mem_write_en) overlap++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_valid = 0; bus.cpu_rw = RW_READ; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.mem_busy = 0; bus.mem_rdata = '0; bus.mem_rdata_valid = 0;
    bus_t.cpu_valid = 0; bus_t.cpu_rw = RW_READ; bus_t.cpu_addr = '0; bus_t.cpu_wdata = '0;
    bus_t.mem_busy = 0; bus_t.mem_rdata = '0; bus_t.mem_rdata_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    repeat (2) cyc();
    reset = 1;
    #1;
    total++; if (bus.cpu_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b exp=1", bus.cpu_rdy); end
    total++; if (bus.mem_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h exp=0000", bus.mem_addr); end
    total++; if (bus.mem_wdata !== 8'h00) begin bad++; $display("FAIL reset_wdata got=%h exp=00", bus.mem_wdata); end
    total++; if (bus.cpu_rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h exp=00", bus.cpu_rdata); end
    total++; if (bus.cpu_rdata_valid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0", bus.cpu_rdata_valid); end
    total++; if (bus.bus_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.bus_err); end
    total++; if ({bus.mem_read_en, bus.mem_write_en} !== 2'b00) begin bad++; $display("FAIL reset_en got=%b exp=00", {bus.mem_read_en, bus.mem_write_en}); end
    total++; if (bus_t.cpu_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy_t got=%b exp=1", bus_t.cpu_rdy); end
  endtask

  task automatic test_stall();
    int busy_en = 0;
    bus.mem_busy = 1;
    bus.cpu_valid = 1; bus.cpu_rw = RW_READ; bus.cpu_addr = 16'hFFFC;
    cyc();
    bus.cpu_valid = 0;
    for (int i = 0; i < 99; i++) begin
      #1;
      if (bus.mem_read_en || bus.mem_write_en) busy_en++;
      cyc();
    end
    total++; if (busy_en !== 0) begin bad++; $display("FAIL stall_no_en got=%0d exp=0", busy_en); end
    total++; if (bus.cpu_rdy !== 1'b0) begin bad++; $display("FAIL stall_rdy got=%b exp=0", bus.cpu_rdy); end
    bus.mem_busy = 0;
    #1;
    total++; if (bus.mem_read_en !== 1'b1) begin bad++; $display("FAIL stall_read_en got=%b exp=1", bus.mem_read_en); end
    total++; if (bus.mem_write_en !== 1'b0) begin bad++; $display("FAIL stall_write_en got=%b exp=0", bus.mem_write_en); end
    total++; if (bus.mem_addr !== 16'hFFFC) begin bad++; $display("FAIL stall_addr got=%h exp=fffc", bus.mem_addr); end
    cyc();
    total++; if (bus.mem_read_en !== 1'b0) begin bad++; $display("FAIL stall_read_once got=%b exp=0", bus.mem_read_en); end
    bus.mem_rdata_valid = 1; bus.mem_rdata = 8'h12;
    cyc();
    bus.mem_rdata_valid = 0;
    #1;
    total++; if (bus.cpu_rdata !== 8'h12) begin bad++; $display("FAIL stall_rdata got=%h exp=12", bus.cpu_rdata); end
    total++; if (bus.cpu_rdata_valid !== 1'b1) begin bad++; $display("FAIL stall_rvalid got=%b exp=1", bus.cpu_rdata_valid); end
  endtask

  task automatic test_read();
    bus.cpu_valid = 1; bus.cpu_rw = RW_READ; bus.cpu_addr = 16'h0200;
    cyc();
    bus.cpu_valid = 0;
    // data pulse in the acceptance cycle must be ignored
    bus.mem_rdata_valid = 1; bus.mem_rdata = 8'h77;
    #1;
    total++; if (bus.mem_read_en !== 1'b1) begin bad++; $display("FAIL read_en got=%b exp=1", bus.mem_read_en); end
    total++; if (bus.mem_addr !== 16'h0200) begin bad++; $display("FAIL read_addr got=%h exp=0200", bus.mem_addr); end
    cyc();
    bus.mem_rdata_valid = 0;
    total++; if (bus.cpu_rdata_valid !== 1'b0) begin bad++; $display("FAIL read_accept_ignored got=%b exp=0", bus.cpu_rdata_valid); end
    total++; if (bus.cpu_rdata !== 8'h12) begin bad++; $display("FAIL read_rdata_hold got=%h exp=12", bus.cpu_rdata); end
    total++; if (bus.cpu_rdy !== 1'b0) begin bad++; $display("FAIL read_wait_rdy got=%b exp=0", bus.cpu_rdy); end
    cyc();
    cyc();
    bus.mem_rdata_valid = 1; bus.mem_rdata = 8'hA9;
    cyc();
    bus.mem_rdata_valid = 0;
    #1;
    total++; if (bus.cpu_rdata !== 8'hA9) begin bad++; $display("FAIL read_rdata got=%h exp=a9", bus.cpu_rdata); end
    total++; if (bus.cpu_rdata_valid !== 1'b1) begin bad++; $display("FAIL read_rvalid got=%b exp=1", bus.cpu_rdata_valid); end
    total++; if (bus.cpu_rdy !== 1'b1) begin bad++; $display("FAIL read_rdy got=%b exp=1", bus.cpu_rdy); end
    cyc();
    total++; if (bus.cpu_rdata_valid !== 1'b0) begin bad++; $display("FAIL read_pulse_once got=%b exp=0", bus.cpu_rdata_valid); end
    total++; if (bus.cpu_rdata !== 8'hA9) begin bad++; $display("FAIL read_rdata_keep got=%h exp=a9", bus.cpu_rdata); end
  endtask

  task automatic test_write();
    bus.mem_busy = 0;
    bus.cpu_valid = 1; bus.cpu_rw = RW_WRITE; bus.cpu_addr = 16'h0300; bus.cpu_wdata = 8'h55;
    cyc();
    bus.cpu_valid = 0;
    #1;
    total++; if (bus.mem_write_en !== 1'b1) begin bad++; $display("FAIL write_en got=%b exp=1", bus.mem_write_en); end
    total++; if (bus.mem_read_en !== 1'b0) begin bad++; $display("FAIL write_no_read got=%b exp=0", bus.mem_read_en); end
    total++; if (bus.mem_wdata !== 8'h55) begin bad++; $display("FAIL write_wdata got=%h exp=55", bus.mem_wdata); end
    total++; if (bus.mem_addr !== 16'h0300) begin bad++; $display("FAIL write_addr got=%h exp=0300", bus.mem_addr); end
    cyc();
    total++; if (bus.mem_write_en !== 1'b0) begin bad++; $display("FAIL write_once got=%b exp=0", bus.mem_write_en); end
    total++; if (bus.cpu_rdy !== 1'b1) begin bad++; $display("FAIL write_rdy got=%b exp=1", bus.cpu_rdy); end
    total++; if (bus.cpu_rdata !== 8'hA9) begin bad++; $display("FAIL write_rdata_keep got=%h exp=a9", bus.cpu_rdata); end
  endtask

  task automatic test_back_to_back();
    overlap = 0;
    bus.cpu_valid = 1; bus.cpu_rw = RW_WRITE; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 8'h3C;
    cyc();
    bus.cpu_valid = 0;
    #1;
    total++; if ({bus.mem_write_en, bus.mem_read_en} !== 2'b10) begin bad++; $display("FAIL b2b_write got=%b exp=10", {bus.mem_write_en, bus.mem_read_en}); end
    cyc();
    bus.cpu_valid = 1; bus.cpu_rw = RW_READ; bus.cpu_addr = 16'h0010;
    #1;
    total++; if ({bus.mem_write_en, bus.mem_read_en} !== 2'b00) begin bad++; $display("FAIL b2b_gap got=%b exp=00", {bus.mem_write_en, bus.mem_read_en}); end
    cyc();
    bus.cpu_valid = 0;
    #1;
    total++; if ({bus.mem_write_en, bus.mem_read_en} !== 2'b01) begin bad++; $display("FAIL b2b_read got=%b exp=01", {bus.mem_write_en, bus.mem_read_en}); end
    cyc();
    bus.mem_rdata_valid = 1; bus.mem_rdata = 8'h3C;
    cyc();
    bus.mem_rdata_valid = 0;
    #1;
    total++; if (bus.cpu_rdata !== 8'h3C) begin bad++; $display("FAIL b2b_rdata got=%h exp=3c", bus.cpu_rdata); end
    total++; if (bus.cpu_rdata_valid !== 1'b1) begin bad++; $display("FAIL b2b_rvalid got=%b exp=1", bus.cpu_rdata_valid); end
    total++; if (overlap !== 0) begin bad++; $display("FAIL b2b_overlap got=%0d exp=0", overlap); end
  endtask

  task automatic test_reset_mid();
    bus.cpu_valid = 1; bus.cpu_rw = RW_READ; bus.cpu_addr = 16'h1234;
    cyc();
    bus.cpu_valid = 0;
    cyc();
    total++; if (bus.mem_addr !== 16'h1234) begin bad++; $display("FAIL mid_addr_pre got=%h exp=1234", bus.mem_addr); end
    reset = 0;
    cyc();
    reset = 1;
    bus.mem_rdata_valid = 1; bus.mem_rdata = 8'hEE;
    #1;
    total++; if (bus.cpu_rdy !== 1'b1) begin bad++; $display("FAIL mid_rdy got=%b exp=1", bus.cpu_rdy); end
    total++; if (bus.mem_addr !== 16'h0000) begin bad++; $display("FAIL mid_addr got=%h exp=0000", bus.mem_addr); end
    total++; if (bus.mem_wdata !== 8'h00) begin bad++; $display("FAIL mid_wdata got=%h exp=00", bus.mem_wdata); end
    total++; if ({bus.mem_read_en, bus.mem_write_en} !== 2'b00) begin bad++; $display("FAIL mid_en got=%b exp=00", {bus.mem_read_en, bus.mem_write_en}); end
    total++; if (bus.bus_err !== 1'b0) begin bad++; $display("FAIL mid_err got=%b exp=0", bus.bus_err); end
    cyc();
    bus.mem_rdata_valid = 0;
    total++; if (bus.cpu_rdata_valid !== 1'b0) begin bad++; $display("FAIL mid_late_rvalid got=%b exp=0", bus.cpu_rdata_valid); end
    total++; if (bus.cpu_rdata !== 8'h00) begin bad++; $display("FAIL mid_rdata got=%h exp=00", bus.cpu_rdata); end
  endtask

  task automatic test_timeout();
    // completion in the limit cycle wins over the watchdog
    bus_t.cpu_valid = 1; bus_t.cpu_rw = RW_READ; bus_t.cpu_addr = 16'h4000;
    cyc();
    bus_t.cpu_valid = 0;
    #1;
    total++; if (bus_t.mem_read_en !== 1'b1) begin bad++; $display("FAIL to_read_en got=%b exp=1", bus_t.mem_read_en); end
    repeat (16) cyc();
    bus_t.mem_rdata_valid = 1; bus_t.mem_rdata = 8'h5A;
    cyc();
    bus_t.mem_rdata_valid = 0;
    #1;
    total++; if (bus_t.cpu_rdata_valid !== 1'b1) begin bad++; $display("FAIL to_edge_rvalid got=%b exp=1", bus_t.cpu_rdata_valid); end
    total++; if (bus_t.cpu_rdata !== 8'h5A) begin bad++; $display("FAIL to_edge_rdata got=%h exp=5a", bus_t.cpu_rdata); end
    total++; if (bus_t.bus_err !== 1'b0) begin bad++; $display("FAIL to_edge_err got=%b exp=0", bus_t.bus_err); end
    // no completion at all
    bus_t.cpu_valid = 1;
    cyc();
    bus_t.cpu_valid = 0;
    repeat (16) cyc();
    total++; if (bus_t.bus_err !== 1'b0) begin bad++; $display("FAIL to_early_err got=%b exp=0", bus_t.bus_err); end
    cyc();
`ifdef MEM_REQ_TIMEOUT_EN
    total++; if (bus_t.bus_err !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", bus_t.bus_err); end
    total++; if (bus_t.cpu_rdy !== 1'b0) begin bad++; $display("FAIL to_rdy got=%b exp=0", bus_t.cpu_rdy); end
    bus_t.mem_rdata_valid = 1; bus_t.mem_rdata = 8'hEE;
    cyc();
    bus_t.mem_rdata_valid = 0;
    total++; if (bus_t.cpu_rdata_valid !== 1'b0) begin bad++; $display("FAIL to_late_rvalid got=%b exp=0", bus_t.cpu_rdata_valid); end
    repeat (20) cyc();
    total++; if ({bus_t.bus_err, bus_t.cpu_rdy} !== 2'b10) begin bad++; $display("FAIL to_hold got=%b exp=10", {bus_t.bus_err, bus_t.cpu_rdy}); end
`else
    repeat (40) cyc();
    total++; if ({bus_t.bus_err, bus_t.cpu_rdy} !== 2'b00) begin bad++; $display("FAIL to_unbounded got=%b exp=00", {bus_t.bus_err, bus_t.cpu_rdy}); end
    bus_t.mem_rdata_valid = 1; bus_t.mem_rdata = 8'hC3;
    cyc();
    bus_t.mem_rdata_valid = 0;
    total++; if (bus_t.cpu_rdata !== 8'hC3) begin bad++; $display("FAIL to_late_rdata got=%h exp=c3", bus_t.cpu_rdata); end
`endif
    reset = 0;
    cyc();
    reset = 1;
    #1;
    total++; if ({bus_t.bus_err, bus_t.cpu_rdy} !== 2'b01) begin bad++; $display("FAIL to_reset got=%b exp=01", {bus_t.bus_err, bus_t.cpu_rdy}); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_read();
    test_write();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_req.md
MEM_REQ -- requirements
Module: mem_req

Interface
REQ-001 Parameter TIMEOUT, default 255, is the cycle limit (1..255) for an outstanding memory access before error.
REQ-002 clk  in  1  clock; all logic SHALL be on the rising edge.
REQ-003 reset  in  1  synchronous, active-low.
REQ-004 cpu_valid  in  1  CPU bus cycle request.
REQ-005 cpu_rw  in  1  1 = read, 0 = write (6502 convention).
REQ-006 cpu_addr  in  16  byte address.
REQ-007 cpu_wdata  in  8  write data.
REQ-008 cpu_rdy  out  1  ready; a transfer occurs on a cycle with cpu_valid && cpu_rdy.
REQ-009 cpu_rdata  out  8  read data, registered.
REQ-010 cpu_rdata_valid  out  1  one-cycle pulse marking valid cpu_rdata.
REQ-011 mem_addr  out  16  address to the memory controller.
REQ-012 mem_wdata  out  8  write data to the memory controller.
REQ-013 mem_read_en  out  1  read request.
REQ-014 mem_write_en  out  1  write request.
REQ-015 mem_busy  in  1  controller busy (BIST, or an access in progress).
REQ-016 mem_rdata  in  8  controller read data.
REQ-017 mem_rdata_valid  in  1  one-cycle pulse marking valid mem_rdata.
REQ-018 bus_err  out  1  sticky timeout error.

Function
REQ-019 States SHALL be: IDLE, REQ, RD_WAIT, ERROR.
REQ-020 cpu_rdy SHALL be 1 exactly when state == IDLE; it is registered and independent of cpu_valid.
REQ-021 IDLE, on a transfer: capture addr, rw and wdata into mem_addr, mem_wdata and an internal rw flag; go to REQ next cycle.
REQ-022 REQ: mem_read_en/mem_write_en (per the rw flag) SHALL be asserted combinationally as state == REQ && !mem_busy; the request is accepted on that cycle.
REQ-023 REQ, on accepted read: go to RD_WAIT. On accepted write: go to IDLE, so cpu_rdy = 1 on the next cycle.
REQ-024 REQ with mem_busy high (including post-reset BIST): hold in REQ with both enables 0, for an unbounded wait subject to REQ-029.
REQ-025 RD_WAIT, on mem_rdata_valid: register mem_rdata into cpu_rdata, pulse cpu_rdata_valid for one cycle and return to IDLE, so cpu_rdy rises in the same cycle as cpu_rdata_valid.
REQ-026 mem_rdata_valid SHALL be ignored in IDLE, in REQ, and in the acceptance cycle itself.
REQ-027 mem_read_en and mem_write_en SHALL never be high together, and each is high for at most one cycle per request.
REQ-028 cpu_rdata SHALL hold its last value until the next read completes.
REQ-029 The timeout counter SHALL:
  - clear on entry to REQ;
  - increment every cycle in REQ or RD_WAIT;
  - on reaching TIMEOUT, force the ERROR state on the next edge.
  A completion arriving in that same cycle wins over the timeout.
REQ-030 ERROR: bus_err = 1, cpu_rdy = 0, enables 0; the state is held until reset.

Reset
REQ-031 With reset low at a clock edge:
  - state = IDLE;
  - cpu_rdy = 1 on the following cycle;
  - mem_addr = 16'h0000, mem_wdata = 8'h00, cpu_rdata = 8'h00;
  - cpu_rdata_valid = 0, bus_err = 0, counter = 0.
REQ-032 Reset mid-access (REQ or RD_WAIT) SHALL abandon the access; a late mem_rdata_valid SHALL produce no cpu_rdata_valid.

Configuration
REQ-033 Macro MEM_REQ_TIMEOUT_EN:
  - Defined: REQ-029/REQ-030 are in force.
  - Undefined: no counter is built, ERROR is unreachable, bus_err is tied 0, and waits are unbounded.

Structure
REQ-034 Shared package mem_pkg SHALL hold the state enumeration, the RW_READ = 1 / RW_WRITE = 0 constants and the address/data width constants (16/8).
REQ-035 Sub-module mem_req_timer (counter plus limit compare) SHALL be instantiated only under MEM_REQ_TIMEOUT_EN.

Verification
REQ-036 Stall on busy: reset released, mem_busy = 1 for 100 cycles, CPU read of 16'hFFFC.
  - Response: no mem_read_en while busy.
  - Response: one-cycle mem_read_en with mem_addr = 16'hFFFC in the first cycle busy = 0.
REQ-037 Read: read of 16'h0200, mem_rdata_valid with 8'hA9 three cycles after accept.
  - Response: cpu_rdata = 8'hA9 with a single cpu_rdata_valid pulse and cpu_rdy = 1 in the same cycle.
REQ-038 Write: write of 16'h0300 = 8'h55 with mem_busy = 0.
  - Response: mem_write_en for one cycle, one cycle after the transfer, with mem_wdata = 8'h55.
  - Response: cpu_rdy = 1 in the cycle after that.
REQ-039 Back-to-back: write 16'h0010 = 8'h3C, then read 16'h0010 returning 8'h3C.
  - Response: strictly ordered enables, never overlapping.
  - Response: cpu_rdata = 8'h3C.
REQ-040 Timeout (MEM_REQ_TIMEOUT_EN, TIMEOUT = 16): read accepted, no mem_rdata_valid.
  - Response: bus_err = 1 and cpu_rdy = 0, held until reset.
  - Response: with the macro undefined, bus_err stays 0 indefinitely.
REQ-041 Reset mid-read: reset pulsed in RD_WAIT, then mem_rdata_valid = 1 with 8'hEE.
  - Response: all outputs at reset values.
  - Response: no cpu_rdata_valid, and cpu_rdata = 8'h00.
